align_shift_fsm: RTL and testbench
==================================

Name: align_shift_fsm

Overview:
- Alignment stage of the half-precision floating-point adder, directly downstream of the operand swap stage.
- Takes the ordered operand pair (operand 1 has the larger or equal exponent) and right-shifts the smaller mantissa by the exponent difference, one bit per cycle.
- Produces guard, round and sticky bits for the later rounding stage.
- Uses a valid/ready handshake on both sides so the adder datapath can be stalled.

Parameters:
- MW, 11: mantissa width including the hidden bit (bit MW-1 sits before the binary point).
- EW, 5: exponent width.
- SHORTCUT, 13: exponent difference at or above which the loop is skipped. Equals MW+2, the width of the mantissa plus guard and round.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  swap stage presents an operand pair
- in_ready  out  1  block can accept; equals (state==IDLE)
- inp1  in  MW  larger-exponent mantissa
- sgn1  in  1  larger-exponent sign
- exp1  in  EW  larger exponent
- inp2  in  MW  smaller-exponent mantissa
- sgn2  in  1  smaller-exponent sign
- exp2  in  EW  smaller exponent
- out_valid  out  1  aligned result available
- out_ready  in  1  downstream accepts result
- out_mant_big  out  MW  inp1, passed through registered
- out_mant_small  out  MW  aligned inp2
- out_guard  out  1  first bit below the aligned LSB
- out_round  out  1  second bit below the aligned LSB
- out_sticky  out  1  OR of all bits shifted past round
- out_exp  out  EW  common exponent (exp1)
- out_sgn_big  out  1  sgn1
- out_sgn_small  out  1  sgn2
- out_eff_sub  out  1  sgn1 XOR sgn2
- err_order  out  1  exp2>exp1 seen on the last accepted pair

Behaviour:
- Reset (rst_n low at an edge):
  - state goes to IDLE.
  - Every registered output clears to 0: out_valid, all out_* data fields, err_order.
  - in_ready reads 1 from the first cycle after reset.
  - Reset has priority over any handshake and any state, including mid-SHIFT; the in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch all inputs.
  - Form a working register ext = {inp2, g=0, r=0} of MW+2 bits; sticky=0.
  - diff = exp1-exp2, unsigned EW bits.
  - If exp2>exp1: set diff=0 and err_order=1. Otherwise err_order=0.
  - If diff==0: go to DONE with ext unchanged.
  - If diff>=SHORTCUT: go to DONE with ext=0 and sticky = OR of inp2.
  - Otherwise: load cnt=diff and go to SHIFT.
- SHIFT (one shift per cycle):
  - ext <= ext>>1.
  - sticky <= sticky | ext[0].
  - cnt <= cnt-1.
  - When cnt==1 at the edge, that is the last shift; go to DONE.
- DONE:
  - out_valid=1.
  - out_mant_small = ext[MW+1:2], out_guard = ext[1], out_round = ext[0], out_sticky = sticky.
  - All outputs hold stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE; out_valid drops next cycle.
- Latency from the accepting edge to out_valid high:
  - 1 cycle for diff==0 or diff>=SHORTCUT.
  - diff+1 cycles otherwise.
- Throughput: at best one pair per latency+1 cycles. There is no acceptance in the same cycle the result is consumed.
- in_valid while not in IDLE is ignored; upstream must hold its data until in_ready.
- Output data registers change only on the IDLE-to-next transition and at reset.
- Width rules:
  - diff is computed in EW bits with no wrap; the order check runs first.
  - cnt is EW bits.
  - diff==SHORTCUT takes the shortcut path, which gives the same result as the loop would.

Test Plan:
- Equal exponents: exp1=exp2=10, inp2=11'h5A5, in_valid for 1 cycle.
  - Required: out_valid 1 cycle after accept.
  - out_mant_small=11'h5A5, guard/round/sticky=0,0,0, out_exp=10.
- Diff 3: exp1=15, exp2=12, inp1=11'h400, inp2=11'h5A5.
  - Required: out_valid 4 cycles after accept.
  - out_mant_small=11'h0B4, guard=1, round=0, sticky=1.
  - out_mant_big=11'h400, out_exp=15.
- Shortcut: exp1=25, exp2=5, inp2=11'h001.
  - Required: out_valid 1 cycle after accept.
  - out_mant_small=0, guard=0, round=0, sticky=1.
  - With inp2=0 instead: sticky=0.
- Backpressure: complete the diff-3 case, then hold out_ready=0 for 5 cycles while in_valid=1 with new data.
  - Required: outputs constant, in_ready=0, new data not latched.
  - Raising out_ready gives IDLE next cycle; the new pair is accepted the cycle after.
- Reset mid-SHIFT: exp1=20, exp2=10; pull rst_n low for 1 cycle on cycle 4 after accept.
  - Required: out_valid never rises for that pair, all outputs 0, in_ready=1 the next cycle.
  - A following pair processes normally.
- Order violation: exp1=3, exp2=7, sgn1=0, sgn2=1.
  - Required: err_order=1, out_valid 1 cycle after accept.
  - Mantissa unshifted, out_eff_sub=1.

Source files
------------

// File: rtl/align_shift_fsm.sv
// Alignment stage of the half-precision adder: right-shifts the smaller-exponent
// mantissa by the exponent difference, one bit per cycle, and collects guard/round/sticky bits.
module align_shift_fsm #(
    parameter int MW       = 11,
    parameter int EW       = 5,
    parameter int SHORTCUT = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [MW-1:0] inp1,
    input  logic          sgn1,
    input  logic [EW-1:0] exp1,
    input  logic [MW-1:0] inp2,
    input  logic          sgn2,
    input  logic [EW-1:0] exp2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_mant_big,
    output logic [MW-1:0] out_mant_small,
    output logic          out_guard,
    output logic          out_round,
    output logic          out_sticky,
    output logic [EW-1:0] out_exp,
    output logic          out_sgn_big,
    output logic          out_sgn_small,
    output logic          out_eff_sub,
    output logic          err_order
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [MW+1:0] ext;       // {mantissa, guard, round}
    logic          sticky;
    logic [EW-1:0] cnt;
    logic [MW-1:0] mant_big;
    logic [EW-1:0] exp_r;
    logic          sgn_b, sgn_s, err_r;

    logic          order_bad;
    logic [EW-1:0] diff;
    logic          far;

    // Order check first so a swapped pair never produces a wrapped difference.
    always_comb begin
        order_bad = (exp2 > exp1);
        diff      = order_bad ? '0 : (exp1 - exp2);
        far       = (int'(diff) >= SHORTCUT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (diff == '0 || far) state_nxt = DONE;
                    else                   state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == EW'(1)) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ext      <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            mant_big <= '0;
            exp_r    <= '0;
            sgn_b    <= 1'b0;
            sgn_s    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant_big <= inp1;
                        exp_r    <= exp1;
                        sgn_b    <= sgn1;
                        sgn_s    <= sgn2;
                        err_r    <= order_bad;
                        cnt      <= diff;
                        // Everything falls below round: only sticky survives.
                        if (far) begin
                            ext    <= '0;
                            sticky <= |inp2;
                        end else begin
                            ext    <= {inp2, 2'b00};
                            sticky <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    ext    <= ext >> 1;
                    sticky <= sticky | ext[0];
                    cnt    <= cnt - EW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready       = (state == IDLE);
    assign out_valid      = (state == DONE);
    assign out_mant_big   = mant_big;
    assign out_mant_small = ext[MW+1:2];
    assign out_guard      = ext[1];
    assign out_round      = ext[0];
    assign out_sticky     = sticky;
    assign out_exp        = exp_r;
    assign out_sgn_big    = sgn_b;
    assign out_sgn_small  = sgn_s;
    assign out_eff_sub    = sgn_b ^ sgn_s;
    assign err_order      = err_r;

endmodule

// File: tb/tb_align_shift_fsm.sv
// Bench for align_shift_fsm: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_align_shift_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] inp1 = '0, inp2 = '0;
    logic        sgn1 = 1'b0, sgn2 = 1'b0;
    logic [4:0]  exp1 = '0, exp2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_mant_big, out_mant_small;
    logic        out_guard, out_round, out_sticky;
    logic [4:0]  out_exp;
    logic        out_sgn_big, out_sgn_small, out_eff_sub, err_order;

    int checks = 0;
    int errors = 0;

    align_shift_fsm #(.MW(11), .EW(5), .SHORTCUT(13)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .inp1(inp1), .sgn1(sgn1), .exp1(exp1),
        .inp2(inp2), .sgn2(sgn2), .exp2(exp2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant_big(out_mant_big), .out_mant_small(out_mant_small),
        .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
        .out_exp(out_exp), .out_sgn_big(out_sgn_big), .out_sgn_small(out_sgn_small),
        .out_eff_sub(out_eff_sub), .err_order(err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Alignment by plain arithmetic on the value {inp2, 00}.
    function automatic void model(input logic [10:0] i2, input logic [4:0] e1, input logic [4:0] e2,
                                  output logic [10:0] ms, output logic g, output logic r,
                                  output logic s, output logic err, output int lat);
        int d;
        logic [12:0] full, sh;
        err  = (e2 > e1);
        d    = err ? 0 : int'(e1) - int'(e2);
        full = {i2, 2'b00};
        if (d >= 13) begin
            ms = '0; g = 1'b0; r = 1'b0; s = |i2; lat = 1;
        end else begin
            sh  = full >> d;
            ms  = sh[12:2]; g = sh[1]; r = sh[0];
            s   = ((full & ((13'd1 << d) - 13'd1)) != 13'd0);
            lat = (d == 0) ? 1 : d + 1;
        end
    endfunction

    // Reference model, advanced on each rising edge.
    logic        m_init = 1'b0, m_idle = 1'b1, m_valid = 1'b0, m_clear = 1'b1;
    int          m_rem = 0;
    logic [10:0] e_big = '0, e_small = '0;
    logic        e_g = 1'b0, e_r = 1'b0, e_s = 1'b0, e_err = 1'b0, e_sb = 1'b0, e_ss = 1'b0;
    logic [4:0]  e_exp = '0;

    always @(posedge clk) begin
        logic [10:0] ms;
        logic g, r, s, err;
        int lat;
        if (!rst_n) begin
            m_init <= 1'b1; m_idle <= 1'b1; m_valid <= 1'b0; m_clear <= 1'b1; m_rem <= 0;
            e_big <= '0; e_small <= '0; e_g <= 1'b0; e_r <= 1'b0; e_s <= 1'b0;
            e_err <= 1'b0; e_sb <= 1'b0; e_ss <= 1'b0; e_exp <= '0;
        end else if (m_idle && in_valid) begin
            model(inp2, exp1, exp2, ms, g, r, s, err, lat);
            e_big <= inp1; e_small <= ms; e_g <= g; e_r <= r; e_s <= s;
            e_err <= err; e_sb <= sgn1; e_ss <= sgn2; e_exp <= exp1;
            m_clear <= 1'b0; m_idle <= 1'b0;
            if (lat == 1) m_valid <= 1'b1;
            else          m_rem <= lat - 1;
        end else if (!m_idle && !m_valid) begin
            if (m_rem == 1) m_valid <= 1'b1;
            m_rem <= m_rem - 1;
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0; m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("in_ready", in_ready, m_idle);
            chk("out_valid", out_valid, m_valid);
            chk("err_order", err_order, e_err);
            if (m_valid || m_clear) begin
                chk("mant_big", out_mant_big, e_big);
                chk("mant_small", out_mant_small, e_small);
                chk("grs", {out_guard, out_round, out_sticky}, {e_g, e_r, e_s});
                chk("exp", out_exp, e_exp);
                chk("sgns", {out_sgn_big, out_sgn_small, out_eff_sub}, {e_sb, e_ss, e_sb ^ e_ss});
            end
        end
    end

    task automatic send(input logic [10:0] i1, input logic s1, input logic [4:0] x1,
                        input logic [10:0] i2, input logic s2, input logic [4:0] x2,
                        input int exp_lat);
        int lat;
        inp1 = i1; sgn1 = s1; exp1 = x1; inp2 = i2; sgn2 = s2; exp2 = x2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] ms;
        logic g, r, s, err;
        int lat;

        // Pin the model with hand-computed values.
        model(11'h5A5, 5'd15, 5'd12, ms, g, r, s, err, lat);
        chk("model_diff3", {21'd0, ms, g, r, s}, {21'd0, 11'h0B4, 1'b1, 1'b0, 1'b1});
        model(11'h400, 5'd19, 5'd7, ms, g, r, s, err, lat);
        chk("model_diff12", {ms, g, r, s, 8'(lat)}, {11'h000, 1'b0, 1'b1, 1'b0, 8'd13});

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);

        // Equal exponents
        send(11'h7FF, 1'b0, 5'd10, 11'h5A5, 1'b0, 5'd10, 1);
        chk("eq_small", out_mant_small, 11'h5A5);
        chk("eq_grs", {out_guard, out_round, out_sticky}, 3'b000);
        chk("eq_exp", out_exp, 5'd10);
        consume();

        // Diff 3, then backpressure with a new pair waiting
        send(11'h400, 1'b0, 5'd15, 11'h5A5, 1'b0, 5'd12, 4);
        chk("d3_small", out_mant_small, 11'h0B4);
        chk("d3_grs", {out_guard, out_round, out_sticky}, 3'b101);
        chk("d3_big", out_mant_big, 11'h400);
        chk("d3_exp", out_exp, 5'd15);
        inp1 = 11'h111; exp1 = 5'd12; inp2 = 11'h123; exp2 = 5'd12;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_small", out_mant_small, 11'h0B4);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_new_valid", out_valid, 1'b1);
        chk("bp_new_small", out_mant_small, 11'h123);
        consume();

        // Shortcut, sticky set and clear
        send(11'h400, 1'b0, 5'd25, 11'h001, 1'b0, 5'd5, 1);
        chk("sc_small", out_mant_small, 11'h000);
        chk("sc_grs", {out_guard, out_round, out_sticky}, 3'b001);
        consume();
        send(11'h400, 1'b0, 5'd25, 11'h000, 1'b0, 5'd5, 1);
        chk("sc0_sticky", out_sticky, 1'b0);
        consume();

        // Boundaries: diff == SHORTCUT and diff == SHORTCUT-1
        send(11'h400, 1'b0, 5'd20, 11'h7FF, 1'b0, 5'd7, 1);
        chk("d13_grs", {out_mant_small, out_guard, out_round, out_sticky}, {11'h000, 3'b001});
        consume();
        send(11'h400, 1'b0, 5'd19, 11'h400, 1'b0, 5'd7, 13);
        chk("d12_grs", {out_mant_small, out_guard, out_round, out_sticky}, {11'h000, 3'b010});
        consume();

        // Reset mid-SHIFT
        inp1 = 11'h6AA; exp1 = 5'd20; inp2 = 11'h7FF; exp2 = 5'd10; sgn1 = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_zero", {out_mant_big, out_mant_small, out_exp, out_sgn_big}, 28'd0);
        repeat (12) @(negedge clk);
        chk("rs_no_valid", out_valid, 1'b0);
        send(11'h555, 1'b0, 5'd9, 11'h403, 1'b0, 5'd7, 3);
        chk("rs_next", {out_mant_small, out_guard, out_round, out_sticky}, {11'h100, 3'b110});
        consume();

        // Order violation
        send(11'h2AA, 1'b0, 5'd3, 11'h3C3, 1'b1, 5'd7, 1);
        chk("ord_err", err_order, 1'b1);
        chk("ord_small", out_mant_small, 11'h3C3);
        chk("ord_effsub", out_eff_sub, 1'b1);
        consume();
        send(11'h2AA, 1'b0, 5'd7, 11'h3C3, 1'b0, 5'd7, 1);
        chk("ord_clear", err_order, 1'b0);
        consume();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
